cpu_regs_sequencer: RTL



---
 rtl/cpu_regs_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/cpu_regs_sequencer.sv
// Architectural register stage of the 4-bit CPU: holds REGS and commits the ALU result on run/step events.
// Optional breakpoint halting is compiled in with `define CPU_BREAKPOINT_EN.

package cpu_regs_pkg;
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] out;
        logic [3:0] pc;
        logic       carry;
    } regs_t;
endpackage

// state | meaning
// ------+--------------------------------------------------------------
// 0     | RESET_WAIT: single settling cycle after reset, no commit
// 1     | RUN: commit on every prescaler terminal count
// 2     | STEP: commit once per synchronised step button press
// 3     | HALT: no commits; a step press with halt_req low resumes
module cpu_regs_sequencer
    import cpu_regs_pkg::*;
#(
    parameter int DIV   = 12_000_000,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_mode,
    input  logic             step_btn,
    input  logic             halt_req,
    input  regs_t            next,
    output regs_t            current,
    output logic             commit,
    output logic [CNT_W-1:0] instr_count,
    output logic [1:0]       state
`ifdef CPU_BREAKPOINT_EN
    ,
    input  logic             bp_en,
    input  logic [3:0]       bp_addr,
    output logic             bp_hit
`endif
);

    typedef enum logic [1:0] {
        S_RESET_WAIT = 2'd0,
        S_RUN        = 2'd1,
        S_STEP       = 2'd2,
        S_HALT       = 2'd3
    } state_t;

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_TC = PW'(DIV - 1);

    state_t           state_q, state_d;
    logic [PW-1:0]    pre_q, pre_d;
    regs_t            cur_q, cur_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             commit_q, commit_d;
    logic             sync1_q, sync2_q, prev_q, pulse_q;
    logic             tick;
    logic             do_commit;
`ifdef CPU_BREAKPOINT_EN
    logic             bp_hit_q, bp_hit_d;
`endif

    // Registered edge pulse: a press sampled at edge k is acted on at edge k+3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= step_btn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= sync2_q & ~prev_q;
        end
    end

    assign tick = (pre_q == PRE_TC);

    always_comb begin
        state_d   = state_q;
        pre_d     = '0;
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        commit_d  = 1'b0;
        do_commit = 1'b0;
`ifdef CPU_BREAKPOINT_EN
        bp_hit_d  = bp_hit_q;
`endif
        case (state_q)
            S_RESET_WAIT: state_d = run_mode ? S_RUN : S_STEP;
            S_RUN: begin
                if (halt_req) begin
                    state_d = S_HALT;
                end else begin
                    do_commit = tick;
                    pre_d     = tick ? '0 : pre_q + PW'(1);
                    if (!run_mode) begin
                        state_d = S_STEP;
                        pre_d   = '0;
                    end
                end
            end
            S_STEP: begin
                if (halt_req) begin
                    state_d = S_HALT;
                end else begin
                    do_commit = pulse_q;
                    if (run_mode) state_d = S_RUN;
                end
            end
            S_HALT: begin
                if (!halt_req && pulse_q) begin
                    state_d = run_mode ? S_RUN : S_STEP;
`ifdef CPU_BREAKPOINT_EN
                    bp_hit_d = 1'b0;
`endif
                end
            end
            default: state_d = S_RESET_WAIT;
        endcase

        if (do_commit) begin
            cur_d    = next;
            cnt_d    = cnt_q + CNT_W'(1);
            commit_d = 1'b1;
`ifdef CPU_BREAKPOINT_EN
            // The matching instruction still commits; the halt follows it.
            if (bp_en && (next.pc == bp_addr)) begin
                state_d  = S_HALT;
                bp_hit_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_RESET_WAIT;
            pre_q    <= '0;
            cur_q    <= '0;
            cnt_q    <= '0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            cur_q    <= cur_d;
            cnt_q    <= cnt_d;
            commit_q <= commit_d;
        end
    end

`ifdef CPU_BREAKPOINT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bp_hit_q <= 1'b0;
        else     bp_hit_q <= bp_hit_d;
    end
    assign bp_hit = bp_hit_q;
`endif

    assign current     = cur_q;
    assign commit      = commit_q;
    assign instr_count = cnt_q;
    assign state       = state_q;

endmodule
